// File: rtl/barycentric_interpolate.sv
// Barycentric interpolation over a stored triangle: p = u*a + v*b + w*c with
// fixed-point weights, four pipeline stages and per-component saturation.
//
// state  | meaning
// EMPTY  | no triangle loaded; samples are dropped
// LOADED | vertices latched; samples accepted one per cycle
module barycentric_interpolate #(
  parameter int COORD_WIDTH = 32
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in_n,
  input  logic signed [2:0][COORD_WIDTH/2-1:0] a,
  input  logic signed [2:0][COORD_WIDTH/2-1:0] b,
  input  logic signed [2:0][COORD_WIDTH/2-1:0] c,
  input  logic                                 init,
  input  logic signed [COORD_WIDTH-1:0]        u,
  input  logic signed [COORD_WIDTH-1:0]        v,
  input  logic signed [COORD_WIDTH-1:0]        w,
  input  logic                                 valid_in,
  output logic signed [2:0][COORD_WIDTH/2-1:0] p,
  output logic                                 valid_out,
  output logic                                 ovf,
  output logic                                 init_done,
  output logic                                 busy
);
  localparam int W  = COORD_WIDTH / 2;
  localparam int FP = COORD_WIDTH / 2;
  localparam int PW = COORD_WIDTH + W;
  localparam int SW = PW + 2;

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t state_q, state_d;
  logic   init_accept, sample_accept;

  logic [2:0][W-1:0]       va, vb, vc;
  logic                    vld1, vld2, vld3, vld4;
  logic [COORD_WIDTH-1:0]  wu, wv, ww;
  logic signed [PW-1:0]    prod [3][3];
  logic signed [SW-1:0]    sum [3];
  logic signed [SW-1:0]    sh [3];
  logic [W-1:0]            sat [3];
  logic                    sat_ovf;
  logic [W-1:0]            res [3];
  logic                    res_ovf;

  function automatic logic signed [PW-1:0] ext_w(input logic [COORD_WIDTH-1:0] x);
    return {{W{x[COORD_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [PW-1:0] ext_c(input logic [W-1:0] x);
    return {{COORD_WIDTH{x[W-1]}}, x};
  endfunction

  function automatic logic signed [SW-1:0] ext_p(input logic [PW-1:0] x);
    return {{2{x[PW-1]}}, x};
  endfunction

  assign busy = vld1 | vld2 | vld3 | vld4;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  // An accepted init takes priority: a sample in the same cycle is dropped.
  always_comb begin
    state_d       = state_q;
    init_accept   = init && !busy;
    sample_accept = valid_in && (state_q == LOADED) && !init_accept;
    if (init_accept) state_d = LOADED;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      va        <= '0;
      vb        <= '0;
      vc        <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= init_accept;
      if (init_accept) begin
        va <= a;
        vb <= b;
        vc <= c;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld1 <= 1'b0;
      wu   <= '0;
      wv   <= '0;
      ww   <= '0;
    end else begin
      vld1 <= sample_accept;
      if (sample_accept) begin
        wu <= u;
        wv <= v;
        ww <= w;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld2 <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          prod[i][j] <= '0;
    end else begin
      vld2 <= vld1;
      for (int j = 0; j < 3; j++) begin
        prod[0][j] <= ext_w(wu) * ext_c(va[j]);
        prod[1][j] <= ext_w(wv) * ext_c(vb[j]);
        prod[2][j] <= ext_w(ww) * ext_c(vc[j]);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld3 <= 1'b0;
      for (int j = 0; j < 3; j++) sum[j] <= '0;
    end else begin
      vld3 <= vld2;
      for (int j = 0; j < 3; j++)
        sum[j] <= ext_p(prod[0][j]) + ext_p(prod[1][j]) + ext_p(prod[2][j]);
    end
  end

  // Arithmetic shift floors; the value fits W bits only if every bit above
  // the result sign matches it.
  always_comb begin
    sat_ovf = 1'b0;
    for (int j = 0; j < 3; j++) begin
      sh[j]  = sum[j] >>> FP;
      sat[j] = sh[j][W-1:0];
      if (!((&sh[j][SW-1:W-1]) || !(|sh[j][SW-1:W-1]))) begin
        sat[j]  = sh[j][SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        sat_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld4    <= 1'b0;
      res_ovf <= 1'b0;
      for (int j = 0; j < 3; j++) res[j] <= '0;
    end else begin
      vld4    <= vld3;
      res_ovf <= sat_ovf;
      for (int j = 0; j < 3; j++) res[j] <= sat[j];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      valid_out <= 1'b0;
      ovf       <= 1'b0;
      p         <= '0;
    end else begin
      valid_out <= vld4;
      if (vld4) begin
        ovf <= res_ovf;
        for (int j = 0; j < 3; j++) p[j] <= res[j];
      end
    end
  end

endmodule

// File: doc/barycentric_interpolate.md
BARYCENTRIC_INTERPOLATE -- requirements
Module: barycentric_interpolate

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 32: barycentric weight width; vertex/result component width is COORD_WIDTH/2 (W); weight fraction bits FP = COORD_WIDTH/2; ONE = 1<<FP.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk_in  input  1  rising-edge clock for all state.
REQ-004 rst_in_n  input  1  asynchronous active-low reset.
REQ-005 a, b, c  input  signed [2:0][W-1:0]  triangle vertices (x,y,z), sampled only on accepted init.
REQ-006 init  input  1  load request for a/b/c.
REQ-007 u, v, w  input  signed [COORD_WIDTH-1:0]  weights for a, b, c (FP fraction bits).
REQ-008 valid_in  input  1  u/v/w valid this cycle.
REQ-009 p  output  signed [2:0][W-1:0]  interpolated point, registered.
REQ-010 valid_out  output  1  p valid, one-cycle pulse per accepted sample.
REQ-011 ovf  output  1  saturation occurred in any component of p; qualified by valid_out.
REQ-012 init_done  output  1  one-cycle pulse after accepted init.
REQ-013 busy  output  1  at least one sample in flight.

Function
REQ-014 FSM states SHALL be EMPTY (no triangle loaded) and LOADED; reset state EMPTY.
REQ-015 init SHALL be accepted when busy=0 in either state: latch a/b/c, go to LOADED, assert init_done the following cycle.
REQ-016 init while busy=1 SHALL be ignored: no vertex change, no init_done.
REQ-017 valid_in in EMPTY, or in the same cycle as an accepted init, SHALL be dropped: no valid_out.
REQ-018 valid_in in LOADED without an accepted init SHALL be accepted; throughput one sample per cycle; no backpressure.
REQ-019 Pipeline SHALL be 4 stages: S1 register u/v/w; S2 nine signed products weight*component (COORD_WIDTH+W bits); S3 per-component sum of three products (COORD_WIDTH+W+2 bits); S4 arithmetic right shift by FP, saturate, register p.
REQ-020 Sample accepted at edge k SHALL produce valid_out=1 after edge k+4, exactly 4 cycles of latency.
REQ-021 Shift SHALL floor toward negative infinity; no rounding.
REQ-022 Result outside [-2^(W-1), 2^(W-1)-1] SHALL saturate to the nearest bound per component; ovf=1 if any component saturated, else 0.
REQ-023 Weights SHALL NOT be range-checked; negative weights or weights above ONE are processed arithmetically.
REQ-024 busy SHALL be the OR of the valid flags in stages S1..S4 before output.
REQ-025 p and ovf SHALL hold their last value while valid_out=0.

Reset
REQ-026 rst_in_n=0 SHALL immediately clear: state EMPTY, stored vertices 0, all pipeline valid flags 0, p=0, valid_out=0, ovf=0, init_done=0, busy=0.
REQ-027 Reset mid-operation SHALL discard in-flight samples; no valid_out for them after release.
REQ-028 After release, a triangle SHALL be reloaded via init before samples are accepted.

Verification (COORD_WIDTH=32, W=16, ONE=0x10000)
REQ-029 init with a=(100,0,0), b=(0,100,0), c=(0,0,100) -> init_done pulse next cycle; then u=0x8000, v=0x4000, w=0x4000 -> 4 cycles later p=(50,25,25), valid_out=1, ovf=0.
REQ-030 a=(-3,-3,-3), b=c=(0,0,0), u=0x8000, v=w=0 -> p=(-2,-2,-2), floor behaviour confirmed.
REQ-031 a=b=(30000,-30000,0), c=0, u=v=ONE, w=0 -> p=(32767,-32768,0), ovf=1.
REQ-032 valid_in pulses before any init, and in the same cycle as init -> no valid_out ever produced for them.
REQ-033 Accept 6 back-to-back samples, assert init on cycle 3 -> init ignored, no init_done, busy=1 throughout; 6 valid_out pulses on consecutive cycles computed with the original vertices.
REQ-034 Accept 3 samples, drop rst_in_n for 1 cycle mid-flight -> all outputs 0 immediately, no valid_out after release; valid_in without init is dropped.
